alarm_zone_controller: RTL and testbench
========================================

ALARM_ZONE_CONTROLLER -- requirements
Module: alarm_zone_controller

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clock cycles per second.
REQ-002 SHALL have parameter N_ZONES, default 4, number of laser zones (1..16).
REQ-003 SHALL have parameter EXIT_DELAY_S, default 10, arming delay in seconds (0 allowed).
REQ-004 SHALL have parameter ENTRY_DELAY_S, default 20, trigger-to-alert delay in seconds (>=1).
REQ-005 SHALL have parameter MAX_ATTEMPTS, default 3, wrong passcodes tolerated in TRIGGER (>=1).
REQ-006 SHALL have parameter TW, default 8, timer width; delays SHALL each be < 2**TW.
REQ-007 SHALL have ports, in order:
- clk  in  1  system clock; one clock.
- rst  in  1  asynchronous, active-low reset.
- arm_btn  in  1  arm pushbutton, active-low level.
- laser_triggered  in  N_ZONES  per-zone beam broken, active-high.
- zone_mask  in  N_ZONES  per-zone enable, 1 = monitored.
- passcode_correct  in  1  one-cycle pulse.
- passcode_wrong  in  1  one-cycle pulse.
- system_state  out  3  IDLE=0, ARMING=1, SET=2, TRIGGER=3, ALERT=4.
- seconds_timer  out  TW  remaining seconds in ARMING/TRIGGER, else 0.
- zones_latched  out  N_ZONES  zones that tripped since last arm.
- wrong_attempts  out  $clog2(MAX_ATTEMPTS+1)  wrong passcodes in current TRIGGER.
- siren  out  1  high only in ALERT.

Function
REQ-008 SHALL generate a 1 Hz tick: prescaler counts 0..CLK_HZ-1, tick asserted in the cycle it equals CLK_HZ-1, then wraps to 0.
REQ-009 SHALL clear the prescaler on every state change, so the first tick after entry occurs exactly CLK_HZ cycles later.
REQ-010 SHALL register arm_btn once and detect a press as registered 1 -> current 0; holding the button SHALL not re-trigger.
REQ-011 IDLE: press -> ARMING, seconds_timer loads EXIT_DELAY_S, zones_latched cleared; if EXIT_DELAY_S = 0 -> SET directly.
REQ-012 ARMING: seconds_timer decrements on each tick; tick with timer = 1 -> SET, timer 0; passcode_correct -> IDLE; laser inputs ignored.
REQ-013 SET: trip = laser_triggered & zone_mask; trip != 0 -> TRIGGER, timer loads ENTRY_DELAY_S, zones_latched |= trip, wrong_attempts cleared.
REQ-014 SET: passcode_correct with trip = 0 -> IDLE; simultaneous trip and passcode_correct -> TRIGGER (trip wins).
REQ-015 TRIGGER: timer decrements per tick; zones_latched |= trip every cycle; passcode_correct -> IDLE.
REQ-016 TRIGGER: tick with timer = 1 -> ALERT; passcode_correct in that same cycle -> IDLE (passcode wins).
REQ-017 TRIGGER: passcode_wrong increments wrong_attempts (saturating); increment reaching MAX_ATTEMPTS -> ALERT in the next cycle, timer 0.
REQ-018 passcode_wrong SHALL be ignored outside TRIGGER; passcode_correct and passcode_wrong together SHALL count as correct only.
REQ-019 ALERT: siren = 1; zones_latched keeps accumulating; passcode_correct -> IDLE; no timeout exit.
REQ-020 On leaving to IDLE, seconds_timer and wrong_attempts SHALL be 0; zones_latched SHALL hold until the next arm press.
REQ-021 State encodings 5..7 SHALL recover to IDLE in the next cycle with all outputs at their reset values.
REQ-022 All outputs SHALL be registered; state changes take effect one clock after the qualifying input edge.

Reset
REQ-023 rst = 0 SHALL asynchronously force: system_state IDLE, seconds_timer 0, zones_latched 0, wrong_attempts 0, siren 0, prescaler 0, arm_btn register 1.
REQ-024 Reset asserted mid-TRIGGER or mid-ALERT SHALL abort immediately; after release, no transition until a new arm press.

Verification (CLK_HZ=4, N_ZONES=4, EXIT_DELAY_S=2, ENTRY_DELAY_S=3, MAX_ATTEMPTS=2)
REQ-025 Arm press, no trips -> ARMING timer 2, 1 after 4 cycles, SET after 8 cycles, timer 0.
REQ-026 In SET, zone_mask=4'b0101, laser_triggered=4'b0010 -> stays SET; laser_triggered=4'b0100 -> TRIGGER, timer 3, zones_latched 4'b0100.
REQ-027 In TRIGGER, no passcode -> ALERT 12 cycles after entry, siren 1; passcode_correct -> IDLE, siren 0, zones_latched held.
REQ-028 In TRIGGER, passcode_correct in expiry-tick cycle -> IDLE, never ALERT.
REQ-029 In TRIGGER, two passcode_wrong pulses -> wrong_attempts 2, ALERT next cycle; a correct+wrong pulse pair -> IDLE, wrong_attempts unchanged.
REQ-030 rst low for 1 cycle in ALERT -> all outputs 0 immediately; held arm_btn low through release -> stays IDLE.

Source files
------------

// File: rtl/alarm_zone_controller.sv
`default_nettype none
// ============================================================================
// Module   : alarm_zone_controller
// Brief    : Laser-zone intrusion alarm. Exit delay after arming, entry delay
//            after a monitored zone trips, passcode disarm, wrong-code lockout
//            and a siren in ALERT. Seconds come from an internal prescaler.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_zone_controller #(
    parameter int CLK_HZ        = 50000000,
    parameter int N_ZONES       = 4,
    parameter int EXIT_DELAY_S  = 10,
    parameter int ENTRY_DELAY_S = 20,
    parameter int MAX_ATTEMPTS  = 3,
    parameter int TW            = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              arm_btn,
    input  logic [N_ZONES-1:0]                laser_triggered,
    input  logic [N_ZONES-1:0]                zone_mask,
    input  logic                              passcode_correct,
    input  logic                              passcode_wrong,
    output logic [2:0]                        system_state,
    output logic [TW-1:0]                     seconds_timer,
    output logic [N_ZONES-1:0]                zones_latched,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] wrong_attempts,
    output logic                              siren
);

    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMING  = 3'd1;
    localparam logic [2:0] S_SET     = 3'd2;
    localparam logic [2:0] S_TRIGGER = 3'd3;
    localparam logic [2:0] S_ALERT   = 3'd4;

    localparam logic [PW-1:0] c_PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [TW-1:0] c_EXIT       = TW'(EXIT_DELAY_S);
    localparam logic [TW-1:0] c_ENTRY      = TW'(ENTRY_DELAY_S);
    localparam logic [TW-1:0] c_T_ONE      = TW'(1);
    localparam logic [AW-1:0] c_ATT_MAX    = AW'(MAX_ATTEMPTS);

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [PW-1:0]      r_presc;
    logic               r_btn;
    logic               r_ready;
    logic [TW-1:0]      r_timer;
    logic [TW-1:0]      w_timer_next;
    logic [N_ZONES-1:0] r_zones;
    logic [N_ZONES-1:0] w_zones_next;
    logic [AW-1:0]      r_att;
    logic [AW-1:0]      w_att_next;
    logic [AW-1:0]      w_att_inc;
    logic               r_siren;

    logic               w_tick;
    logic               w_press;
    logic [N_ZONES-1:0] w_trip;
    logic               w_wrong_max;
    logic               w_expire;

    assign w_tick      = (r_presc == c_PRESC_LAST);
    // The first edge after reset release is ignored so that a button already
    // held down while reset was asserted does not look like a fresh press.
    assign w_press     = r_ready & r_btn & ~arm_btn;
    assign w_trip      = laser_triggered & zone_mask;
    assign w_att_inc   = (r_att == c_ATT_MAX) ? r_att : r_att + AW'(1);
    assign w_wrong_max = passcode_wrong & (w_att_inc == c_ATT_MAX);
    assign w_expire    = w_tick & (r_timer == c_T_ONE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; passcode_correct dominates wherever it disarms
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_state_next = (EXIT_DELAY_S == 0) ? S_SET : S_ARMING;
                end
            end
            S_ARMING: begin
                if (passcode_correct)  w_state_next = S_IDLE;
                else if (w_expire)     w_state_next = S_SET;
            end
            S_SET: begin
                if (w_trip != '0)          w_state_next = S_TRIGGER;
                else if (passcode_correct) w_state_next = S_IDLE;
            end
            S_TRIGGER: begin
                if (passcode_correct)             w_state_next = S_IDLE;
                else if (w_wrong_max || w_expire) w_state_next = S_ALERT;
            end
            S_ALERT: begin
                if (passcode_correct) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs (timer, latched zones, attempts)
    always_comb begin
        w_timer_next = r_timer;
        w_zones_next = r_zones;
        w_att_next   = r_att;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_timer_next = c_EXIT;
                    w_zones_next = '0;
                end
            end
            S_ARMING: begin
                if (passcode_correct) w_timer_next = '0;
                else if (w_tick)      w_timer_next = r_timer - c_T_ONE;
            end
            S_SET: begin
                if (w_trip != '0) begin
                    w_timer_next = c_ENTRY;
                    w_zones_next = r_zones | w_trip;
                    w_att_next   = '0;
                end
            end
            S_TRIGGER: begin
                w_zones_next = r_zones | w_trip;
                if (passcode_correct) begin
                    w_timer_next = '0;
                    w_att_next   = '0;
                end else begin
                    if (passcode_wrong) w_att_next = w_att_inc;
                    if (w_wrong_max || w_expire) w_timer_next = '0;
                    else if (w_tick)             w_timer_next = r_timer - c_T_ONE;
                end
            end
            S_ALERT: begin
                w_zones_next = r_zones | w_trip;
                if (passcode_correct) w_att_next = '0;
            end
            default: begin
                w_timer_next = '0;
                w_zones_next = '0;
                w_att_next   = '0;
            end
        endcase
    end

    // Datapath registers, 1 Hz prescaler (restarted on any state change) and
    // the button history used for falling-edge press detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
            r_zones <= '0;
            r_att   <= '0;
            r_siren <= 1'b0;
            r_presc <= '0;
            r_btn   <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            r_timer <= w_timer_next;
            r_zones <= w_zones_next;
            r_att   <= w_att_next;
            r_siren <= (w_state_next == S_ALERT);
            r_btn   <= arm_btn;
            r_ready <= 1'b1;
            if (w_state_next != r_state || w_tick) r_presc <= '0;
            else                                   r_presc <= r_presc + PW'(1);
        end
    end

    assign system_state   = r_state;
    assign seconds_timer  = r_timer;
    assign zones_latched  = r_zones;
    assign wrong_attempts = r_att;
    assign siren          = r_siren;

endmodule
`default_nettype wire

// File: tb/tb_alarm_zone_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_zone_controller
// Brief    : Self-checking bench for alarm_zone_controller. Directed scenarios
//            plus random stimulus compared against a seconds-by-age model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_zone_controller;

    localparam int c_CLK_HZ = 4;
    localparam int c_NZ     = 4;
    localparam int c_EXIT   = 2;
    localparam int c_ENTRY  = 3;
    localparam int c_MAXA   = 2;
    localparam int c_TW     = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             arm_btn = 1'b1;
    logic [c_NZ-1:0]  laser_triggered = '0;
    logic [c_NZ-1:0]  zone_mask = '0;
    logic             passcode_correct = 1'b0;
    logic             passcode_wrong = 1'b0;
    logic [2:0]       system_state;
    logic [c_TW-1:0]  seconds_timer;
    logic [c_NZ-1:0]  zones_latched;
    logic [1:0]       wrong_attempts;
    logic             siren;
    logic [17:0]      w_dut;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state number, cycles spent in that state, latched
    // zones, wrong count, previous button level, post-reset qualifier.
    int              m_state;
    int              m_age;
    int              m_att;
    logic [c_NZ-1:0] m_zones;
    logic            m_prev_btn;
    logic            m_ready;

    alarm_zone_controller #(
        .CLK_HZ(c_CLK_HZ), .N_ZONES(c_NZ), .EXIT_DELAY_S(c_EXIT),
        .ENTRY_DELAY_S(c_ENTRY), .MAX_ATTEMPTS(c_MAXA), .TW(c_TW)
    ) dut (
        .clk(clk), .rst(rst), .arm_btn(arm_btn),
        .laser_triggered(laser_triggered), .zone_mask(zone_mask),
        .passcode_correct(passcode_correct), .passcode_wrong(passcode_wrong),
        .system_state(system_state), .seconds_timer(seconds_timer),
        .zones_latched(zones_latched), .wrong_attempts(wrong_attempts),
        .siren(siren)
    );

    assign w_dut = {system_state, seconds_timer, zones_latched, wrong_attempts, siren};

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_age = 0; m_att = 0; m_zones = '0;
        m_prev_btn = 1'b1; m_ready = 1'b0;
    endtask

    // One clock of the alarm rules: delays expire once the state has lasted
    // exactly DELAY seconds worth of cycles.
    task automatic model_step();
        int              ns;
        logic            press;
        logic [c_NZ-1:0] trip;
        press = m_ready && m_prev_btn && !arm_btn;
        trip  = laser_triggered & zone_mask;
        ns    = m_state;
        case (m_state)
            0: if (press) begin ns = (c_EXIT == 0) ? 2 : 1; m_zones = '0; end
            1: if (passcode_correct) ns = 0;
               else if (m_age == c_EXIT * c_CLK_HZ - 1) ns = 2;
            2: if (trip != 0) begin ns = 3; m_zones |= trip; m_att = 0; end
               else if (passcode_correct) ns = 0;
            3: begin
                m_zones |= trip;
                if (passcode_correct) begin ns = 0; m_att = 0; end
                else begin
                    if (passcode_wrong && m_att < c_MAXA) m_att++;
                    if (m_att == c_MAXA || m_age == c_ENTRY * c_CLK_HZ - 1) ns = 4;
                end
            end
            4: begin
                m_zones |= trip;
                if (passcode_correct) begin ns = 0; m_att = 0; end
            end
            default: ns = 0;
        endcase
        m_age      = (ns != m_state) ? 0 : m_age + 1;
        m_state    = ns;
        m_prev_btn = arm_btn;
        m_ready    = 1'b1;
    endtask

    function automatic logic [17:0] exp_vec();
        int t;
        t = 0;
        if (m_state == 1)      t = c_EXIT  - m_age / c_CLK_HZ;
        else if (m_state == 3) t = c_ENTRY - m_age / c_CLK_HZ;
        return {3'(m_state), 8'(t), m_zones, 2'(m_att), (m_state == 4)};
    endfunction

    // Advance one clock; returns 1 time unit after the edge.
    task automatic clk_cycle();
        @(posedge clk);
        if (!rst) model_reset(); else model_step();
        #1;
    endtask

    // Drive from any state into TRIGGER with the given trip pattern.
    task automatic go_trigger(input logic [c_NZ-1:0] trip);
        arm_btn = 1'b1;
        if (m_state != 0) begin passcode_correct = 1'b1; clk_cycle(); passcode_correct = 1'b0; end
        clk_cycle();
        arm_btn = 1'b0; clk_cycle(); arm_btn = 1'b1;
        repeat (c_EXIT * c_CLK_HZ) clk_cycle();
        zone_mask = '1; laser_triggered = trip; clk_cycle(); laser_triggered = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; arm_btn = 1'b1; model_reset();
        repeat (2) clk_cycle();
        n_tests++;
        if (w_dut !== 18'd0) begin n_fail++; $display("FAIL reset_hold: got %h expected 0", w_dut); end
        rst = 1'b1;
        clk_cycle();
        n_tests++;
        if (w_dut !== exp_vec() || system_state !== 3'd0) begin
            n_fail++; $display("FAIL reset_release: got %h expected %h", w_dut, exp_vec());
        end
    endtask

    task automatic test_arming();
        arm_btn = 1'b1; clk_cycle();
        arm_btn = 1'b0; clk_cycle(); arm_btn = 1'b1;
        n_tests++;
        if (system_state !== 3'd1 || seconds_timer !== 8'd2) begin
            n_fail++; $display("FAIL arming_entry: got st=%0d t=%0d expected st=1 t=2", system_state, seconds_timer);
        end
        for (int i = 1; i <= 8; i++) begin
            clk_cycle();
            n_tests++;
            if (w_dut !== exp_vec()) begin n_fail++; $display("FAIL arming_cyc%0d: got %h expected %h", i, w_dut, exp_vec()); end
            if (i == 4) begin
                n_tests++;
                if (seconds_timer !== 8'd1) begin n_fail++; $display("FAIL arming_t1: got %0d expected 1", seconds_timer); end
            end
        end
        n_tests++;
        if (system_state !== 3'd2 || seconds_timer !== 8'd0) begin
            n_fail++; $display("FAIL arming_set: got st=%0d t=%0d expected st=2 t=0", system_state, seconds_timer);
        end
    endtask

    task automatic test_set_mask();
        zone_mask = 4'b0101; laser_triggered = 4'b0010;
        repeat (3) begin
            clk_cycle();
            n_tests++;
            if (system_state !== 3'd2 || w_dut !== exp_vec()) begin
                n_fail++; $display("FAIL set_masked: got %h expected %h", w_dut, exp_vec());
            end
        end
        laser_triggered = 4'b0100; clk_cycle(); laser_triggered = '0;
        n_tests++;
        if (system_state !== 3'd3 || seconds_timer !== 8'd3 || zones_latched !== 4'b0100) begin
            n_fail++; $display("FAIL set_trip: got st=%0d t=%0d z=%b expected st=3 t=3 z=0100",
                               system_state, seconds_timer, zones_latched);
        end
    endtask

    task automatic test_alert_timeout();
        for (int i = 1; i <= 12; i++) begin
            clk_cycle();
            n_tests++;
            if (w_dut !== exp_vec()) begin n_fail++; $display("FAIL timeout_cyc%0d: got %h expected %h", i, w_dut, exp_vec()); end
            if (i == 11) begin
                n_tests++;
                if (system_state !== 3'd3) begin n_fail++; $display("FAIL timeout_early: got st=%0d expected 3", system_state); end
            end
        end
        n_tests++;
        if (system_state !== 3'd4 || siren !== 1'b1) begin
            n_fail++; $display("FAIL timeout_alert: got st=%0d siren=%b expected st=4 siren=1", system_state, siren);
        end
        passcode_correct = 1'b1; clk_cycle(); passcode_correct = 1'b0;
        n_tests++;
        if (system_state !== 3'd0 || siren !== 1'b0 || zones_latched !== 4'b0100) begin
            n_fail++; $display("FAIL alert_disarm: got st=%0d siren=%b z=%b expected st=0 siren=0 z=0100",
                               system_state, siren, zones_latched);
        end
    endtask

    task automatic test_expiry_passcode();
        go_trigger(4'b1000);
        repeat (11) clk_cycle();
        passcode_correct = 1'b1; clk_cycle(); passcode_correct = 1'b0;
        n_tests++;
        if (system_state !== 3'd0 || siren !== 1'b0 || zones_latched !== 4'b1000 || seconds_timer !== 8'd0) begin
            n_fail++; $display("FAIL expiry_pass: got %h expected st=0 z=1000", w_dut);
        end
        repeat (4) begin
            clk_cycle();
            n_tests++;
            if (system_state !== 3'd0 || w_dut !== exp_vec()) begin
                n_fail++; $display("FAIL expiry_stay_idle: got %h expected %h", w_dut, exp_vec());
            end
        end
    endtask

    task automatic test_wrong_attempts();
        go_trigger(4'b0001);
        passcode_wrong = 1'b1; clk_cycle(); passcode_wrong = 1'b0;
        n_tests++;
        if (system_state !== 3'd3 || wrong_attempts !== 2'd1) begin
            n_fail++; $display("FAIL wrong_one: got st=%0d att=%0d expected st=3 att=1", system_state, wrong_attempts);
        end
        clk_cycle();
        passcode_wrong = 1'b1; clk_cycle(); passcode_wrong = 1'b0;
        n_tests++;
        if (system_state !== 3'd4 || wrong_attempts !== 2'd2 || siren !== 1'b1 || seconds_timer !== 8'd0) begin
            n_fail++; $display("FAIL wrong_lockout: got %h expected st=4 att=2 siren=1 t=0", w_dut);
        end
        go_trigger(4'b0010);
        passcode_wrong = 1'b1; clk_cycle();
        passcode_correct = 1'b1; clk_cycle();
        passcode_wrong = 1'b0; passcode_correct = 1'b0;
        n_tests++;
        if (system_state !== 3'd0 || wrong_attempts !== 2'd0 || siren !== 1'b0 || w_dut !== exp_vec()) begin
            n_fail++; $display("FAIL correct_and_wrong: got %h expected %h", w_dut, exp_vec());
        end
    endtask

    task automatic test_reset_in_alert();
        go_trigger(4'b0100);
        passcode_wrong = 1'b1; clk_cycle(); clk_cycle(); passcode_wrong = 1'b0;
        n_tests++;
        if (system_state !== 3'd4) begin n_fail++; $display("FAIL rst_alert_setup: got st=%0d expected 4", system_state); end
        rst = 1'b0; arm_btn = 1'b0; model_reset();
        #1;
        n_tests++;
        if (w_dut !== 18'd0) begin n_fail++; $display("FAIL rst_async: got %h expected 0", w_dut); end
        clk_cycle();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clk_cycle();
            n_tests++;
            if (system_state !== 3'd0 || w_dut !== exp_vec()) begin
                n_fail++; $display("FAIL rst_held_btn%0d: got %h expected %h", i, w_dut, exp_vec());
            end
        end
        arm_btn = 1'b1; clk_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            arm_btn          = ($urandom_range(0, 15) != 0);
            laser_triggered  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 31) == 0) zone_mask = 4'($urandom);
            passcode_correct = ($urandom_range(0, 19) == 0);
            passcode_wrong   = ($urandom_range(0, 5) == 0);
            clk_cycle();
            n_tests++;
            if (w_dut !== exp_vec()) begin
                n_fail++; $display("FAIL random_cyc%0d: got %h expected %h", i, w_dut, exp_vec());
            end
        end
        arm_btn = 1'b1; laser_triggered = '0; passcode_correct = 1'b0; passcode_wrong = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_arming();
        test_set_mask();
        test_alert_timeout();
        test_expiry_passcode();
        test_wrong_attempts();
        test_reset_in_alert();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
